// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: a single FSM shares one ALU and one memory
// port across the fetch, decode, execute, memory and write-back phases.
module legv8_multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      op_code,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALU_op,
    output logic             Reg2Loc,
    output logic             Mem2Reg,
    output logic             RegWrite,
    output logic [3:0]       state,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        WB_LD    = 4'd6,
        MEM_WR   = 4'd7,
        BR_CBZ   = 4'd8,
        BR_UNC   = 4'd9,
        FAULT    = 4'd15
    } state_t;

    state_t          cur;
    logic [1:0]      fault_r;
    logic [CNT_W-1:0] retired_r;
    logic [WW-1:0]   wait_cnt;

    logic is_ldur, is_stur, is_rtype, is_cbz, is_b;
    logic mem_wait, timeout_hit;

    assign is_ldur  = (op_code == OP_LDUR);
    assign is_stur  = (op_code == OP_STUR);
    assign is_rtype = (op_code == OP_ADD) || (op_code == OP_SUB) || (op_code == OP_AND) ||
                      (op_code == OP_ORR) || (op_code == OP_LSL) || (op_code == OP_LSR);
    assign is_cbz   = (op_code[10:3] == 8'b10110100);
    assign is_b     = (op_code[10:5] == 6'b000101);

    // A wait cycle is any memory phase without mem_ready; the one that would
    // exceed TIMEOUT consecutive waits diverts to FAULT instead.
    assign mem_wait    = ((cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR)) && !mem_ready;
    assign timeout_hit = (TIMEOUT != 0) && mem_wait && (wait_cnt == WW'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= FETCH;
            fault_r   <= 2'b00;
            retired_r <= '0;
            wait_cnt  <= '0;
        end else if (cur != FAULT) begin
            if (timeout_hit) begin
                cur      <= FAULT;
                fault_r  <= 2'b10;
                wait_cnt <= '0;
            end else if (mem_wait) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
                case (cur)
                    FETCH:    cur <= DECODE;
                    DECODE: begin
                        if (is_ldur || is_stur) cur <= MEM_ADDR;
                        else if (is_rtype)      cur <= EXEC_R;
                        else if (is_cbz)        cur <= BR_CBZ;
                        else if (is_b)          cur <= BR_UNC;
                        else begin
                            cur     <= FAULT;
                            fault_r <= 2'b01;
                        end
                    end
                    EXEC_R:   cur <= WB_R;
                    MEM_ADDR: cur <= is_stur ? MEM_WR : MEM_RD;
                    MEM_RD:   cur <= WB_LD;
                    WB_R, WB_LD, MEM_WR, BR_CBZ, BR_UNC: begin
                        cur       <= FETCH;
                        retired_r <= retired_r + CNT_W'(1);
                    end
                    default:  cur <= FETCH;
                endcase
            end
        end
    end

    // Strobes decode from state; reset masks them so nothing leaks while held.
    always_comb begin
        mem_req  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALU_op   = 2'b00;
        Reg2Loc  = 1'b0;
        Mem2Reg  = 1'b0;
        RegWrite = 1'b0;
        if (!reset) begin
            case (cur)
                FETCH: begin
                    mem_req = !timeout_hit;
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALU_op  = 2'b10;
                end
                WB_R: begin
                    RegWrite = 1'b1;
                    ALU_op   = 2'b10;
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    Reg2Loc = is_stur;
                end
                MEM_RD: begin
                    mem_req = !timeout_hit;
                    MemRead = 1'b1;
                end
                WB_LD: begin
                    RegWrite = 1'b1;
                    Mem2Reg  = 1'b1;
                end
                MEM_WR: begin
                    mem_req  = !timeout_hit;
                    MemWrite = 1'b1;
                    Reg2Loc  = 1'b1;
                end
                BR_CBZ: begin
                    Reg2Loc = 1'b1;
                    ALUSrcA = 1'b1;
                    ALU_op  = 2'b01;
                    PCSrc   = 1'b1;
                    PCWrite = zero;
                end
                BR_UNC: begin
                    PCSrc   = 1'b1;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state   = cur;
    assign fault   = fault_r;
    assign retired = retired_r;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: directed scenarios with literal expectations plus a
// random run compared every cycle against a phase-plan model of the instruction flow.
module tb_legv8_multicycle_ctrl;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [10:0]      op_code = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALU_op;
    logic             Reg2Loc, Mem2Reg, RegWrite;
    logic [3:0]       state;
    logic [1:0]       fault;
    logic [CNT_W-1:0] retired;
    logic [13:0]      dut_strb;

    int checks = 0;
    int failures = 0;

    legv8_multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALU_op(ALU_op), .Reg2Loc(Reg2Loc), .Mem2Reg(Mem2Reg), .RegWrite(RegWrite),
        .state(state), .fault(fault), .retired(retired)
    );

    assign dut_strb = {mem_req, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, ALUSrcA,
                       ALUSrcB, ALU_op, Reg2Loc, Mem2Reg, RegWrite};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction model: DECODE turns the opcode into a list of phases that follow;
    // memory phases (FETCH, MEM_RD, MEM_WR) hold until mem_ready or time out.
    int          m_state = 0, m_fault = 0, m_ret = 0, m_wait = 0, m_plen = 0, m_pidx = 0;
    logic [11:0] m_plan = '0;

    function automatic logic [15:0] plan_of(input logic [10:0] op);
        if (op == 11'b11111000010) return {4'd3, 4'd4, 4'd5, 4'd6};
        if (op == 11'b11111000000) return {4'd2, 4'd4, 4'd7, 4'd0};
        if (op == 11'b10001011000 || op == 11'b11001011000 || op == 11'b10001010000 ||
            op == 11'b10101010000 || op == 11'b11010011011 || op == 11'b11010011010)
            return {4'd2, 4'd2, 4'd3, 4'd0};
        if (op ==? 11'b10110100???) return {4'd1, 4'd8, 4'd0, 4'd0};
        if (op ==? 11'b000101?????) return {4'd1, 4'd9, 4'd0, 4'd0};
        return 16'h0;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [15:0] p;
        if (reset) begin
            m_state <= 0; m_fault <= 0; m_ret <= 0; m_wait <= 0; m_plen <= 0; m_pidx <= 0;
        end else if (m_state == 15) begin
            m_state <= 15;
        end else if ((m_state == 0 || m_state == 5 || m_state == 7) && !mem_ready) begin
            if (TIMEOUT != 0 && m_wait == TIMEOUT) begin
                m_state <= 15; m_fault <= 2; m_wait <= 0;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else begin
            m_wait <= 0;
            if (m_state == 0) begin
                m_state <= 1;
            end else if (m_state == 1) begin
                p = plan_of(op_code);
                if (p[15:12] == 0) begin
                    m_state <= 15; m_fault <= 1;
                end else begin
                    m_plan <= p[11:0]; m_plen <= int'(p[15:12]); m_pidx <= 1;
                    m_state <= int'(p[11:8]);
                end
            end else if (m_pidx < m_plen) begin
                m_state <= int'(m_plan[11 - 4*m_pidx -: 4]);
                m_pidx  <= m_pidx + 1;
            end else begin
                m_state <= 0;
                m_ret   <= (m_ret + 1) % (1 << CNT_W);
            end
        end
    end

    function automatic logic [13:0] exp_strb(input int st, input logic [10:0] op,
                                             input logic rdy, input logic z, input int w);
        logic mr, pw, ps, ir, rd, wr, sa, r2, m2, rw, to;
        logic [1:0] sb, ao;
        {mr, pw, ps, ir, rd, wr, sa, r2, m2, rw} = '0;
        sb = 2'b00; ao = 2'b00;
        to = (TIMEOUT != 0) && !rdy && (w == TIMEOUT);
        case (st)
            0: begin mr = !to; rd = 1; sb = 2'b01; ir = rdy; pw = rdy; end
            2: begin sa = 1; ao = 2'b10; end
            3: begin rw = 1; ao = 2'b10; end
            4: begin sa = 1; sb = 2'b10; r2 = (op == 11'b11111000000); end
            5: begin mr = !to; rd = 1; end
            6: begin rw = 1; m2 = 1; end
            7: begin mr = !to; wr = 1; r2 = 1; end
            8: begin r2 = 1; sa = 1; ao = 2'b01; ps = 1; pw = z; end
            9: begin ps = 1; pw = 1; end
            default: ;
        endcase
        return {mr, pw, ps, ir, rd, wr, sa, sb, ao, r2, m2, rw};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_strobes", 32'(dut_strb), 32'h0);
        end else begin
            chk("strobes", 32'(dut_strb), 32'(exp_strb(m_state, op_code, mem_ready, zero, m_wait)));
            chk("state", 32'(state), 32'(m_state));
            chk("fault", 32'(fault), 32'(m_fault));
            chk("retired", 32'(retired), 32'(m_ret));
        end
    end

    // Leaves the DUT in FETCH, just after a rising edge, with reset released.
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drive(input logic rdy, input logic z);
        mem_ready = rdy;
        zero = z;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk); #1;
    endtask

    logic [10:0] legal [10];
    int lowrun = 0, fage = 0;

    initial begin
        legal = '{11'b11111000010, 11'b11111000000, 11'b10001011000, 11'b11001011000,
                  11'b10001010000, 11'b10101010000, 11'b11010011011, 11'b11010011010,
                  11'b10110100000, 11'b00010100000};

        // reset values
        reset = 1'b1;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);

        // ADD: states 0,1,2,3,0
        do_reset();
        op_code = 11'b10001011000;
        for (int c = 1; c <= 5; c++) begin
            int st[5] = '{0, 1, 2, 3, 0};
            drive(1'b1, 1'b0);
            chk("add_state", 32'(state), 32'(st[c-1]));
            chk("add_regwrite", 32'(RegWrite), (c == 4) ? 32'd1 : 32'd0);
            if (c == 5) begin
                chk("add_retired", 32'(retired), 32'd1);
                chk("add_fault", 32'(fault), 32'd0);
            end
            advance();
        end

        // LDUR with 3 wait cycles in MEM_RD
        do_reset();
        op_code = 11'b11111000010;
        for (int c = 1; c <= 9; c++) begin
            int st[9] = '{0, 1, 4, 5, 5, 5, 5, 6, 0};
            drive(!(c >= 4 && c <= 6), 1'b0);
            chk("ldur_state", 32'(state), 32'(st[c-1]));
            if (c == 8) chk("ldur_wb", 32'({RegWrite, Mem2Reg}), 32'h3);
            if (c == 9) chk("ldur_retired", 32'(retired), 32'd1);
            advance();
        end

        // CBZ taken then not taken
        do_reset();
        op_code = 11'b10110100101;
        for (int c = 1; c <= 7; c++) begin
            drive(1'b1, (c <= 3));
            if (c == 3) chk("cbz_taken", 32'({state, PCWrite, PCSrc}), {26'd0, 4'd8, 2'b11});
            if (c == 6) chk("cbz_not_taken", 32'({state, PCWrite, PCSrc}), {26'd0, 4'd8, 2'b01});
            if (c == 7) chk("cbz_retired", 32'(retired), 32'd2);
            advance();
        end

        // B
        do_reset();
        op_code = 11'b00010100000;
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 1'b0);
            chk("b_regwrite", 32'(RegWrite), 32'd0);
            if (c == 3) chk("b_branch", 32'({state, PCWrite, PCSrc}), {26'd0, 4'd9, 2'b11});
            if (c == 4) chk("b_retired", 32'(retired), 32'd1);
            advance();
        end

        // illegal opcode: sticky fault, inputs ignored
        do_reset();
        op_code = 11'b11111111111;
        drive(1'b1, 1'b0); advance();
        drive(1'b1, 1'b0); advance();
        for (int c = 0; c < 20; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("ill_state", 32'(state), 32'd15);
            chk("ill_fault", 32'(fault), 32'd1);
            chk("ill_strobes", 32'(dut_strb), 32'd0);
            advance();
        end
        reset = 1'b1;
        #1;
        chk("ill_rst_state", 32'(state), 32'd0);
        chk("ill_rst_fault", 32'(fault), 32'd0);
        #1 reset = 1'b0;
        advance();

        // FETCH timeout: 15 waits, then the 16th drops mem_req and faults
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            drive(1'b0, 1'b0);
            if (c <= 16) chk("to_state", 32'(state), 32'd0);
            if (c <= 16) chk("to_mem_req", 32'(mem_req), (c <= 15) ? 32'd1 : 32'd0);
            if (c == 17) chk("to_fault", 32'({state, fault}), {26'd0, 4'd15, 2'd2});
            advance();
        end

        // mem_ready on the boundary cycle beats the timeout
        do_reset();
        op_code = 11'b10001011000;
        for (int c = 1; c <= 17; c++) begin
            drive(c == 16, 1'b0);
            if (c == 16) chk("win_handshake", 32'({mem_req, IRWrite}), 32'h3);
            if (c == 17) chk("win_state", 32'({state, fault}), {26'd0, 4'd1, 2'd0});
            advance();
        end

        // reset mid-MEM_WR
        do_reset();
        op_code = 11'b11111000000;
        for (int c = 1; c <= 3; c++) begin
            drive(1'b1, 1'b0);
            advance();
        end
        drive(1'b0, 1'b0);
        chk("stur_memwrite", 32'({state, MemWrite}), {27'd0, 4'd7, 1'b1});
        #1 reset = 1'b1;
        #1;
        chk("stur_rst_strobes", 32'({MemWrite, mem_req}), 32'd0);
        chk("stur_rst_state", 32'({state, retired}), 32'd0);
        advance();
        #1 reset = 1'b0;

        // random run against the model
        for (int i = 0; i < 4000; i++) begin
            if (reset) begin
                reset = 1'b0;
            end else if ((m_state == 15 && fage >= 4) || $urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                fage = 0;
            end
            fage = (m_state == 15) ? fage + 1 : 0;
            if (m_state == 0 && !reset) begin
                int r = $urandom_range(0, 39);
                if (r < 38) begin
                    op_code = legal[r % 10];
                    if (r % 10 == 8) op_code[2:0] = 3'($urandom);
                    if (r % 10 == 9) op_code[4:0] = 5'($urandom);
                end else begin
                    op_code = 11'($urandom);
                end
            end
            if (lowrun == 0 && $urandom_range(0, 29) == 0) lowrun = $urandom_range(1, 18);
            if (lowrun > 0) begin
                mem_ready = 1'b0;
                lowrun--;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
